// File: rtl/disp_strip_sequencer_if.sv
// Bundle of the pixel-in, engine-control and disparity-out signals of the strip sequencer.
//   master : environment side (pixel source, disparity engine, result sink)
//   slave  : sequencer side
interface disp_strip_sequencer_if #(
    parameter int unsigned WIN       = 15,
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned IMG_W     = 64,
    parameter int unsigned DISP_BITS = 4,
    parameter int unsigned IMG_W_ARR = 6
);
    localparam int unsigned StripW = DATA_SIZE * IMG_W * WIN;

    // pixel stream
    logic                 pix_valid;
    logic [DATA_SIZE-1:0] pix_L;
    logic [DATA_SIZE-1:0] pix_R;
    logic                 pix_ready;
    // engine side
    logic [StripW-1:0]    strip_L;
    logic [StripW-1:0]    strip_R;
    logic [IMG_W_ARR-1:0] col_index;
    logic                 input_ready;
    logic                 eng_rst;
    logic                 eng_done;
    logic [DISP_BITS-1:0] eng_disp;
    // result stream
    logic                 disp_valid;
    logic [DISP_BITS-1:0] disp_out;
    logic [IMG_W_ARR-1:0] disp_col;
    logic                 disp_ready;
    logic                 strip_done;

    modport master (
        output pix_valid, pix_L, pix_R, eng_done, eng_disp, disp_ready,
        input  pix_ready, strip_L, strip_R, col_index, input_ready, eng_rst,
               disp_valid, disp_out, disp_col, strip_done
    );

    modport slave (
        input  pix_valid, pix_L, pix_R, eng_done, eng_disp, disp_ready,
        output pix_ready, strip_L, strip_R, col_index, input_ready, eng_rst,
               disp_valid, disp_out, disp_col, strip_done
    );
endinterface

// File: rtl/disp_strip_sequencer.sv
// Loads a WIN-row strip of left/right pixels from a raster stream, then steps col_index over
// every valid column: reset the disparity engine, pulse input_ready, wait for done, and emit
// the disparity on a ready/valid stream. strip_done pulses after the last column is accepted.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of disp_strip_sequencer_if (pixel in, engine control, result out)
module disp_strip_sequencer #(
    parameter int unsigned WIN          = 15,
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned IMG_W        = 64,
    parameter int unsigned MAX_DISP     = 16,
    parameter int unsigned DISP_BITS    = 4,
    parameter int unsigned IMG_W_ARR    = 6,
    parameter int unsigned LAST_COL     = 34,
    parameter int unsigned PIX_IDX_BITS = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    disp_strip_sequencer_if.slave bus
);
    localparam int unsigned NumPix = WIN * IMG_W;
    localparam int unsigned StripW = DATA_SIZE * NumPix;
    localparam logic [PIX_IDX_BITS-1:0] LastIdx = PIX_IDX_BITS'(NumPix - 1);
    localparam logic [IMG_W_ARR-1:0]    LastCol = IMG_W_ARR'(LAST_COL);

    typedef enum logic [2:0] {
        StLoad,
        StEngRst,
        StIssue,
        StWait,
        StEmit
    } state_e;

    state_e                state_q, state_d;
    logic [PIX_IDX_BITS-1:0] wr_idx_q, wr_idx_d;
    logic [IMG_W_ARR-1:0]  col_q, col_d;
    logic [StripW-1:0]     strip_l_q, strip_l_d;
    logic [StripW-1:0]     strip_r_q, strip_r_d;
    logic                  disp_valid_q, disp_valid_d;
    logic [DISP_BITS-1:0]  disp_out_q, disp_out_d;
    logic [IMG_W_ARR-1:0]  disp_col_q, disp_col_d;
    logic                  strip_done_q, strip_done_d;

    always_comb begin
        state_d      = state_q;
        wr_idx_d     = wr_idx_q;
        col_d        = col_q;
        strip_l_d    = strip_l_q;
        strip_r_d    = strip_r_q;
        disp_valid_d = disp_valid_q;
        disp_out_d   = disp_out_q;
        disp_col_d   = disp_col_q;
        strip_done_d = 1'b0;

        case (state_q)
            StLoad: begin
                // pix_ready is 1 throughout LOAD, so pix_valid alone is the handshake
                if (bus.pix_valid) begin
                    strip_l_d[int'(wr_idx_q) * DATA_SIZE +: DATA_SIZE] = bus.pix_L;
                    strip_r_d[int'(wr_idx_q) * DATA_SIZE +: DATA_SIZE] = bus.pix_R;
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d = '0;
                        col_d    = '0;
                        state_d  = StEngRst;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            StEngRst: state_d = StIssue;
            StIssue:  state_d = StWait;
            StWait: begin
                if (bus.eng_done) begin
                    disp_out_d   = bus.eng_disp;
                    disp_col_d   = col_q;
                    disp_valid_d = 1'b1;
                    state_d      = StEmit;
                end
            end
            StEmit: begin
                if (bus.disp_ready) begin
                    disp_valid_d = 1'b0;
                    if (col_q == LastCol) begin
                        strip_done_d = 1'b1;
                        state_d      = StLoad;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = StEngRst;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StLoad;
            wr_idx_q     <= '0;
            col_q        <= '0;
            strip_l_q    <= '0;
            strip_r_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_out_q   <= '0;
            disp_col_q   <= '0;
            strip_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_idx_q     <= wr_idx_d;
            col_q        <= col_d;
            strip_l_q    <= strip_l_d;
            strip_r_q    <= strip_r_d;
            disp_valid_q <= disp_valid_d;
            disp_out_q   <= disp_out_d;
            disp_col_q   <= disp_col_d;
            strip_done_q <= strip_done_d;
        end
    end

    // Engine is held in reset for the whole load and between columns.
    assign bus.pix_ready   = (state_q == StLoad);
    assign bus.eng_rst     = (state_q == StLoad) || (state_q == StEngRst);
    assign bus.input_ready = (state_q == StIssue);
    assign bus.strip_L     = strip_l_q;
    assign bus.strip_R     = strip_r_q;
    assign bus.col_index   = col_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.disp_out    = disp_out_q;
    assign bus.disp_col    = disp_col_q;
    assign bus.strip_done  = strip_done_q;

endmodule

// File: tb/tb_disp_strip_sequencer.sv
module tb_disp_strip_sequencer;
    localparam int unsigned WIN = 15, DATA_SIZE = 8, IMG_W = 64, MAX_DISP = 16;
    localparam int unsigned DISP_BITS = 4, IMG_W_ARR = 6, LAST_COL = 34, PIX_IDX_BITS = 10;
    localparam int NumPix = WIN * IMG_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    disp_strip_sequencer_if #(
        .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .DISP_BITS(DISP_BITS),
        .IMG_W_ARR(IMG_W_ARR)
    ) bus ();

    disp_strip_sequencer #(
        .WIN(WIN), .DATA_SIZE(DATA_SIZE), .IMG_W(IMG_W), .MAX_DISP(MAX_DISP),
        .DISP_BITS(DISP_BITS), .IMG_W_ARR(IMG_W_ARR), .LAST_COL(LAST_COL),
        .PIX_IDX_BITS(PIX_IDX_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [5:0] col;
        logic [3:0] disp;
    } exp_t;

    exp_t     exp_q[$];
    int       compared = 0;
    int       mismatched = 0;
    int       cyc = 0;
    int       sd_count = 0;
    bit [7:0] model_l[NumPix];
    bit [7:0] model_r[NumPix];
    bit [3:0] disp_tab[64];
    bit       rnd_ready = 0;
    bit       hold_en = 0;
    int       hold_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_reset(input string name);
        compared++;
        if (!(bus.pix_ready === 1'b1 && bus.eng_rst === 1'b1 && bus.input_ready === 1'b0 &&
              bus.disp_valid === 1'b0 && bus.strip_done === 1'b0 && bus.col_index === '0 &&
              bus.disp_out === '0 && bus.disp_col === '0 && bus.strip_L === '0 &&
              bus.strip_R === '0)) begin
            mismatched++;
            $display("FAIL %s: pr=%b er=%b ir=%b dv=%b sd=%b ci=%0d do=%0d dc=%0d sLz=%b sRz=%b",
                     name, bus.pix_ready, bus.eng_rst, bus.input_ready, bus.disp_valid,
                     bus.strip_done, bus.col_index, bus.disp_out, bus.disp_col,
                     bus.strip_L === '0, bus.strip_R === '0);
        end
    endtask

    task automatic check_strips(input string name);
        int bad = -1;
        for (int i = 0; i < NumPix; i++) begin
            if (bad < 0 && (bus.strip_L[i*8 +: 8] !== model_l[i] ||
                            bus.strip_R[i*8 +: 8] !== model_r[i]))
                bad = i;
        end
        compared++;
        if (bad >= 0) begin
            mismatched++;
            $display("FAIL %s: byte %0d got L=%0d R=%0d required L=%0d R=%0d", name, bad,
                     bus.strip_L[bad*8 +: 8], bus.strip_R[bad*8 +: 8], model_l[bad],
                     model_r[bad]);
        end
    endtask

    // Streams one full strip. rnd: random data instead of the k / k+7 ramp; gap: pix_valid
    // toggles every other cycle. Returns in the cycle after the final accepted pair.
    task automatic load_strip(input bit rnd, input bit gap);
        int k = 0;
        int n = 0;
        bit acc;
        while (k < NumPix && n < 4000) begin
            @(posedge clk); #1;
            n++;
            bus.pix_valid = gap ? n[0] : 1'b1;
            bus.pix_L = rnd ? 8'($urandom) : 8'(k);
            bus.pix_R = rnd ? 8'($urandom) : 8'(k + 7);
            @(negedge clk);
            acc = bus.pix_valid && bus.pix_ready;
            if (acc) begin
                model_l[k] = bus.pix_L;
                model_r[k] = bus.pix_R;
                k++;
            end
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        if (k < NumPix) chk("load_timeout", k, NumPix);
        for (int c = 0; c <= int'(LAST_COL); c++)
            exp_q.push_back('{col: 6'(c), disp: disp_tab[c]});
    endtask

    // Waits for strip_done; garbage drives pix_valid=1 with random data outside LOAD.
    task automatic wait_strip_done(input bit garbage, input string name);
        int start = sd_count;
        int n = 0;
        while (sd_count == start && n < 6000) begin
            @(posedge clk); #1;
            n++;
            bus.pix_valid = garbage && !bus.pix_ready;
            bus.pix_L = 8'($urandom);
            bus.pix_R = 8'($urandom);
        end
        bus.pix_valid = 1'b0;
        if (sd_count == start) chk(name, 0, 1);
    endtask

    // Engine model: done rises 5 cycles after input_ready, cleared by eng_rst.
    initial begin
        int cnt = 0;
        bit busy = 0;
        bus.eng_done = 1'b0;
        bus.eng_disp = '0;
        forever begin
            @(posedge clk); #1;
            if (!bus.eng_done) bus.eng_disp = 4'($urandom);
            if (!rst_n || bus.eng_rst) begin
                bus.eng_done = 1'b0;
                busy = 0;
            end else if (bus.input_ready) begin
                busy = 1;
                cnt = 5;
            end else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_disp = disp_tab[bus.col_index];
                    busy = 0;
                end
            end
        end
    end

    // Result sink ready: optional random stalls, plus a 10-cycle hold at column 3.
    initial begin
        bus.disp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (hold_en && bus.disp_valid && bus.disp_col == 6'd3 && hold_cnt < 10) begin
                bus.disp_ready = 1'b0;
                hold_cnt++;
            end else begin
                bus.disp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit   stall = 0;
        bit   hs_pend = 0;
        int   hs_cyc = 0;
        int   last_col = -1;
        logic [3:0] p_out;
        logic [5:0] p_col, p_ci;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 0;
                hs_pend = 0;
                last_col = -1;
            end else begin
                if (stall) begin
                    compared++;
                    if (!(bus.disp_valid && bus.disp_out == p_out && bus.disp_col == p_col &&
                          bus.col_index == p_ci && !bus.input_ready)) begin
                        mismatched++;
                        $display("FAIL hold: dv=%b do=%0d dc=%0d ci=%0d ir=%b required do=%0d dc=%0d ci=%0d",
                                 bus.disp_valid, bus.disp_out, bus.disp_col, bus.col_index,
                                 bus.input_ready, p_out, p_col, p_ci);
                    end
                end
                stall = 0;
                if (bus.disp_valid) begin
                    if (bus.disp_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", bus.disp_col, 63);
                        end else begin
                            e = exp_q.pop_front();
                            chk("disp_col", bus.disp_col, e.col);
                            chk("disp_out", bus.disp_out, e.disp);
                            chk("col_index_emit", bus.col_index, e.col);
                        end
                        last_col = int'(bus.disp_col);
                        hs_pend = (bus.disp_col != 6'(LAST_COL));
                        hs_cyc = cyc;
                    end else begin
                        stall = 1;
                        p_out = bus.disp_out;
                        p_col = bus.disp_col;
                        p_ci = bus.col_index;
                    end
                end
                if (bus.input_ready && hs_pend) begin
                    chk("issue_latency", cyc - hs_cyc, 2);
                    hs_pend = 0;
                end
                if (bus.strip_done) begin
                    sd_count++;
                    chk("strip_done_col", last_col, LAST_COL);
                    chk("strip_done_pix_ready", bus.pix_ready, 1);
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_L = '0;
        bus.pix_R = '0;
        repeat (3) @(posedge clk);
        #1 check_reset("reset_init");
        @(negedge clk) rst_n = 1'b1;

        // Strip 1: ramp data, disp = col mod 16, no stalls; check load-to-issue timing.
        for (int c = 0; c < 64; c++) disp_tab[c] = 4'(c % 16);
        load_strip(0, 0);
        chk("eng_rst_cycle_pix_ready", bus.pix_ready, 0);
        chk("eng_rst_cycle_eng_rst", bus.eng_rst, 1);
        chk("eng_rst_cycle_input_ready", bus.input_ready, 0);
        check_strips("load_ramp");
        @(posedge clk); #1;
        chk("issue_eng_rst", bus.eng_rst, 0);
        chk("issue_input_ready", bus.input_ready, 1);
        chk("issue_col_index", bus.col_index, 0);
        @(posedge clk); #1;
        chk("input_ready_width", bus.input_ready, 0);
        wait_strip_done(0, "strip1_timeout");

        // Strip 2: gapped random load, random stalls, hold at col 3, pixels during WAIT.
        for (int c = 0; c < 64; c++) disp_tab[c] = 4'($urandom);
        rnd_ready = 1;
        hold_en = 1;
        hold_cnt = 0;
        load_strip(1, 1);
        check_strips("load_gapped");
        wait_strip_done(1, "strip2_timeout");
        check_strips("pix_ignored_outside_load");
        hold_en = 0;

        // Strip 3: reset while waiting on column 10.
        for (int c = 0; c < 64; c++) disp_tab[c] = 4'($urandom);
        load_strip(1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.col_index == 6'd10 && !bus.disp_valid && !bus.input_ready &&
                     !bus.eng_rst) && n < 3000);
        if (n >= 3000) chk("wait_col10_timeout", n, 0);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_wait");
        exp_q.delete();
        for (int i = 0; i < NumPix; i++) begin
            model_l[i] = 8'h00;
            model_r[i] = 8'h00;
        end
        @(negedge clk);
        check_reset("reset_held");
        rst_n = 1'b1;

        // Strip 4: fresh load after reset, results from col 0.
        for (int c = 0; c < 64; c++) disp_tab[c] = 4'($urandom);
        load_strip(1, 0);
        check_strips("load_after_reset");
        wait_strip_done(0, "strip4_timeout");

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        chk("strip_done_count", sd_count, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
